// File: rtl/branch_ctrl_pkg.sv
// Shared branch funct3 encodings, BHT counter states and saturating counter helpers.
package branch_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    function automatic bht_state_e bhtInc(input bht_state_e s);
        bht_state_e r;
        r = ST;
        case (s)
            SNT:     r = WNT;
            WNT:     r = WT;
            default: r = ST;
        endcase
        return r;
    endfunction

    function automatic bht_state_e bhtDec(input bht_state_e s);
        bht_state_e r;
        r = SNT;
        case (s)
            ST:      r = WT;
            WT:      r = WNT;
            default: r = SNT;
        endcase
        return r;
    endfunction

    // 010 and 011 are not conditional branches.
    function automatic logic isLegalF3(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters: one async read port, one sync write port.
module branch_bht
    import branch_ctrl_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rdIdx_i,
    output logic [1:0]       rdState_o,
    input  logic             wrEn_i,
    input  logic [IDX_W-1:0] wrIdx_i,
    input  logic             wrTaken_i
);

    bht_state_e bhtTable_q [2**IDX_W];
    bht_state_e entry_d;

    assign rdState_o = bhtTable_q[rdIdx_i];

    always_comb begin
        entry_d = wrTaken_i ? bhtInc(bhtTable_q[wrIdx_i]) : bhtDec(bhtTable_q[wrIdx_i]);
    end

    // Reset starts every entry weakly not-taken and wins over a same-edge update.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                bhtTable_q[i] <= WNT;
            end
        end else if (wrEn_i) begin
            bhtTable_q[wrIdx_i] <= entry_d;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution, ID-stage prediction and mispredict flush with performance counters.
// Define BRANCH_BHT_EN for dynamic BHT prediction; otherwise prediction is static not-taken.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_id_valid,
    input  logic             i_id_is_br,
    input  logic [31:0]      i_id_pc,
    input  logic [31:0]      i_id_target,
    output logic             o_id_redirect,
    output logic [31:0]      o_id_redirect_pc,
    output logic             o_id_pred_taken,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_br,
    input  logic [2:0]       i_ex_funct3,
    input  logic [31:0]      i_ex_pc,
    input  logic [31:0]      i_ex_target,
    input  logic             i_ex_pred_taken,
    output logic             o_br_un,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    output logic             o_ex_taken,
    output logic             o_flush,
    output logic [31:0]      o_ex_redirect_pc,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mispred_count
);

    logic             condTaken;
    logic             exTaken;
    logic             exFire;
    logic             exPred;
    logic             mispredict;
    logic             idPredTaken;
    logic [CNT_W-1:0] brCount_q;
    logic [CNT_W-1:0] brCount_d;
    logic [CNT_W-1:0] mispredCount_q;
    logic [CNT_W-1:0] mispredCount_d;

    assign o_br_un = i_ex_funct3[1];

    always_comb begin
        condTaken = 1'b0;
        case (i_ex_funct3)
            F3_BEQ:  condTaken = i_br_equal;
            F3_BNE:  condTaken = ~i_br_equal;
            F3_BLT:  condTaken = i_br_less;
            F3_BGE:  condTaken = ~i_br_less;
            F3_BLTU: condTaken = i_br_less;
            F3_BGEU: condTaken = ~i_br_less;
            default: condTaken = 1'b0;
        endcase
    end

    assign exTaken    = i_ex_valid & i_ex_is_br & condTaken;
    assign exFire     = i_ex_valid & i_ex_is_br & isLegalF3(i_ex_funct3) & ~i_stall;
    assign mispredict = exFire & (exTaken != exPred);

    assign o_ex_taken       = exTaken;
    assign o_flush          = mispredict;
    assign o_ex_redirect_pc = exTaken ? i_ex_target : i_ex_pc + 32'd4;

`ifdef BRANCH_BHT_EN
    logic [1:0] idState;
    logic       unusedIdPcBits;

    branch_bht #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .rdIdx_i  (i_id_pc[BHT_IDX_W+1:2]),
        .rdState_o(idState),
        .wrEn_i   (exFire),
        .wrIdx_i  (i_ex_pc[BHT_IDX_W+1:2]),
        .wrTaken_i(exTaken)
    );

    assign idPredTaken    = i_id_valid & i_id_is_br & idState[1];
    assign exPred         = i_ex_pred_taken;
    assign unusedIdPcBits = ^{i_id_pc[31:BHT_IDX_W+2], i_id_pc[1:0]};
`else
    logic unusedIdInputs;

    // Static not-taken: the EX-side prediction is always 0, so every taken branch flushes.
    assign idPredTaken    = 1'b0;
    assign exPred         = 1'b0;
    assign unusedIdInputs = ^{i_id_valid, i_id_is_br, i_id_pc, i_ex_pred_taken};
`endif

    assign o_id_pred_taken  = idPredTaken;
    assign o_id_redirect    = idPredTaken & ~mispredict;
    assign o_id_redirect_pc = i_id_target;

    always_comb begin
        brCount_d      = brCount_q;
        mispredCount_d = mispredCount_q;
        if (exFire) begin
            brCount_d = brCount_q + CNT_W'(1);
        end
        if (mispredict) begin
            mispredCount_d = mispredCount_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            brCount_q      <= '0;
            mispredCount_q <= '0;
        end else begin
            brCount_q      <= brCount_d;
            mispredCount_q <= mispredCount_d;
        end
    end

    assign o_br_count      = brCount_q;
    assign o_mispred_count = mispredCount_q;

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and prediction controller for the 5-stage pipeline. It owns the branch comparator: it selects the comparison mode and evaluates `funct3` against the less/equal flags for the branch in EX. It also predicts branches in ID with a 2-bit saturating branch history table (BHT), and raises flush/redirect when a prediction is wrong. It sits between the ID/EX pipeline registers and the PC-select/flush logic, and keeps branch and mispredict counters.

## Interface
Parameters:
- `BHT_IDX_W`, 6, log2 of BHT entries; index = `pc[BHT_IDX_W+1:2]`
- `CNT_W`, 32, width of performance counters

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_stall`  in  1  pipeline stall; freezes all state updates
- `i_id_valid`  in  1  ID slot holds a valid instruction
- `i_id_is_br`  in  1  ID instruction is a conditional branch
- `i_id_pc`  in  32  ID instruction PC
- `i_id_target`  in  32  ID-computed branch target (pc+imm)
- `o_id_redirect`  out  1  predicted taken: fetch from `o_id_redirect_pc`
- `o_id_redirect_pc`  out  32  = `i_id_target`
- `o_id_pred_taken`  out  1  prediction, carried down the pipe to EX
- `i_ex_valid`  in  1  EX slot valid (not a bubble)
- `i_ex_is_br`  in  1  EX instruction is a conditional branch
- `i_ex_funct3`  in  3  branch funct3
- `i_ex_pc`  in  32  EX instruction PC
- `i_ex_target`  in  32  EX branch target
- `i_ex_pred_taken`  in  1  prediction made in ID for this instruction
- `o_br_un`  out  1  drives comparator unsigned select
- `i_br_less`, `i_br_equal`  in  1 each  comparator results
- `o_ex_taken`  out  1  resolved direction
- `o_flush`  out  1  mispredict: kill IF/ID and ID/EX contents
- `o_ex_redirect_pc`  out  32  correct next PC on mispredict
- `o_br_count`, `o_mispred_count`  out  CNT_W each  performance counters

## Operation
- `o_br_un` = `i_ex_funct3[1]`, so BLTU/BGEU compare unsigned. This is combinational.
- Resolution by funct3:
  - 000 BEQ = equal; 001 BNE = !equal
  - 100 BLT and 110 BLTU = less; 101 BGE and 111 BGEU = !less
  - 010 and 011 are resolved not-taken and are not counted.
- `ex_fire` = `i_ex_valid & i_ex_is_br & legal funct3 & !i_stall`.
- Mispredict = `ex_fire & (taken != i_ex_pred_taken)`. It asserts `o_flush`.
  - `o_ex_redirect_pc` = taken ? `i_ex_target` : `i_ex_pc + 4`. It is don't-care when there is no flush.
- BHT: 2^BHT_IDX_W two-bit counters with states SNT=00, WNT=01, WT=10, ST=11.
  - Prediction = `counter[1]`.
  - On `ex_fire`: taken increments the counter, saturating at ST; not-taken decrements it, saturating at SNT.
- `o_id_pred_taken` = `i_id_valid & i_id_is_br & counter[idx(i_id_pc)][1]`. `o_id_redirect` equals `o_id_pred_taken` and is suppressed while `o_flush` is high, because EX redirect has priority.
- Counters:
  - `o_br_count` increments on `ex_fire`; `o_mispred_count` increments on mispredict.
  - Both wrap modulo 2^CNT_W.

## Timing
- Prediction, resolution, flush and redirect are combinational within the cycle and add zero latency.
- BHT update and counter increment are visible from the next cycle.
- Same-cycle ID read and EX update of the same index: ID sees the old value. There is no bypass.
- `i_stall` high: no BHT or counter change. Combinational outputs still reflect current inputs, but `o_flush` is forced 0.
- Reset values: all BHT entries WNT, both counters 0. Outputs are combinational, so with inputs idle they are `o_flush`=0, `o_id_redirect`=0, `o_ex_taken`=0.
- Reset asserted mid-operation: the state clear happens at the next edge regardless of `i_stall`, and reset overrides any same-edge update.

## Configuration
- `BRANCH_BHT_EN` defined: dynamic BHT prediction as described.
- Not defined:
  - No BHT storage; static not-taken prediction, so `o_id_pred_taken` and `o_id_redirect` are tied 0.
  - Every taken branch flushes.
  - Counters remain.

## Structure
- `branch_ctrl_pkg`: funct3 constants (`F3_BEQ`…`F3_BGEU`), `bht_state_e` enum (SNT/WNT/WT/ST), and the saturating increment/decrement functions.
- Sub-module `branch_bht`:
  - One asynchronous read port and one synchronous write port.
  - Inputs are index, update enable and taken; it implements the reset-to-WNT behaviour.
  - It is instantiated only under `BRANCH_BHT_EN`.

## Test plan
- Reset, then BEQ in EX with equal=1 and pred=0 → `o_ex_taken`=1, `o_flush`=1, `o_ex_redirect_pc`=`i_ex_target`, `o_br_count`=1, `o_mispred_count`=1.
- BLTU, funct3=110 → `o_br_un`=1. BLT, funct3=100 → `o_br_un`=0. With less=1, both are resolved taken.
- Same PC 0x100 resolved taken 3 times → BHT index 0x00 goes WNT→WT→ST→ST. Then ID at 0x100 → `o_id_redirect`=1 with `o_id_redirect_pc`=target.
- Predicted-taken BNE at 0x200 with equal=1 → flush, redirect 0x204. Asserting `i_stall` in the same cycle instead → no flush and no counter change.
- funct3=010 with valid branch → not taken, no flush, counters unchanged.
- Preload `o_mispred_count`=2^CNT_W−1 by forcing, then one mispredict → wraps to 0. Asserting `i_rst_n`=0 mid-stream → counters 0 and BHT WNT after one edge.
